// File: rtl/dmem_pkg.sv
// dmem_pkg: funct3 encodings, FSM state encoding and access-size decode shared by dmem_ctrl.
package dmem_pkg;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Anything not recognised as a byte or half access is treated as a word.
    function automatic size_t f3_size(input logic mem_w, input logic [2:0] f3);
        return (f3 == F3_LB || (!mem_w && f3 == F3_LBU)) ? SZ_B :
               (f3 == F3_LH || (!mem_w && f3 == F3_LHU)) ? SZ_H : SZ_W;
    endfunction

    function automatic logic f3_bad(input logic mem_w, input logic [2:0] f3);
        return mem_w ? (f3 > F3_SW) : (f3 == 3'b011 || f3[2:1] == 2'b11);
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: single-port DEPTH_WORDS x 32 RAM, per-byte write enable, registered read.
module dmem_ram #(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic                           i_en,
    input  logic [3:0]                     i_be,
    input  logic [$clog2(DEPTH_WORDS)-1:0] i_idx,
    input  logic [31:0]                    i_wdata,
    output logic [31:0]                    o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_en) begin
            for (int b = 0; b < 4; b++)
                if (i_be[b]) r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
            r_rdata <= r_mem[i_idx];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: RISC-V load/store data memory controller with programmable wait states.
// DMEM_ERR_EN enables rejection of misaligned / undefined-funct3 accesses via err.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        mem_w,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        rsp_valid,
    output logic        err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_t        r_state, w_next;
    logic [3:0]    r_cnt;
    logic          r_mem_w, r_err;
    logic [2:0]    r_f3;
    logic [AW+1:0] r_addr;
    logic [31:0]   r_wdata, r_rdata;
    logic          w_hs, w_bad, w_ram_en, w_unused;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata, w_ram_rdata, w_ext, w_rsp;
    logic [7:0]    w_b;
    logic [15:0]   w_h;
    size_t         w_size;

    assign w_hs     = req_valid & req_ready;
    assign w_size   = f3_size(r_mem_w, r_f3);
    assign w_unused = ^addr[31:AW+2];

`ifdef DMEM_ERR_EN
    size_t w_size_in;
    assign w_size_in = f3_size(mem_w, funct3);
    assign w_bad = f3_bad(mem_w, funct3) | (w_size_in == SZ_H & addr[0]) |
                   (w_size_in == SZ_W & |addr[1:0]);
`else
    assign w_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   w_next = !w_hs ? S_IDLE : w_bad ? S_RESP : (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
            S_WAIT:   w_next = (r_cnt == 4'(WAIT_CYCLES - 1)) ? S_ACCESS : S_WAIT;
            S_ACCESS: w_next = S_RESP;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = r_state == S_IDLE;
        rsp_valid = r_state == S_RESP;
        w_ram_en  = r_state == S_ACCESS;
        w_be      = !(w_ram_en && r_mem_w) ? 4'b0000 :
                    w_size == SZ_B ? 4'b0001 << r_addr[1:0] :
                    w_size == SZ_H ? (r_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_mem_w <= 1'b0;
            r_f3    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_cnt <= (r_state == S_WAIT) ? r_cnt + 4'd1 : 4'd0;
            if (w_hs) begin
                r_mem_w <= mem_w;
                r_f3    <= funct3;
                r_addr  <= addr[AW+1:0];
                r_wdata <= wdata;
                r_err   <= w_bad;
            end
            if (rsp_valid) r_rdata <= w_rsp;
        end
    end

    // Store data replicated across lanes; byte enables select the target lanes.
    assign w_wdata = w_size == SZ_B ? {4{r_wdata[7:0]}} :
                     w_size == SZ_H ? {2{r_wdata[15:0]}} : r_wdata;

    dmem_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
        .clk    (clk),
        .i_en   (w_ram_en),
        .i_be   (w_be),
        .i_idx  (r_addr[AW+1:2]),
        .i_wdata(w_wdata),
        .o_rdata(w_ram_rdata)
    );

    assign w_b   = 8'(w_ram_rdata >> {r_addr[1:0], 3'b000});
    assign w_h   = 16'(w_ram_rdata >> {r_addr[1], 4'b0000});
    assign w_ext = w_size == SZ_B ? {{24{!r_f3[2] & w_b[7]}}, w_b} :
                   w_size == SZ_H ? {{16{!r_f3[2] & w_h[15]}}, w_h} : w_ram_rdata;
    assign w_rsp = (r_err | r_mem_w) ? 32'd0 : w_ext;
    assign rdata = rsp_valid ? w_rsp : r_rdata;

`ifdef DMEM_ERR_EN
    assign err = rsp_valid & r_err;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed vectors, reset corner cases and randomized loads/stores
// checked against a byte-array memory model of dmem_ctrl.
module tb_dmem_ctrl;

`ifdef DMEM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif
    localparam int WC = 1;

    logic        clk = 1'b0, reset = 1'b1, req_valid = 1'b0, mem_w = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] addr = '0, wdata = '0;
    logic        req_ready, rsp_valid, err;
    logic [31:0] rdata;

    always #5 clk = ~clk;

    dmem_ctrl #(.DEPTH_WORDS(1024), .WAIT_CYCLES(WC)) dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .mem_w    (mem_w),
        .funct3   (funct3),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .rsp_valid(rsp_valid),
        .err      (err)
    );

    int n_chk = 0, n_fail = 0;
    logic [7:0] ref_b [4096];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Little-endian byte memory; 4 KiB wraps like the 1024-word RAM.
    function automatic void model(input logic mw, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] wd, output logic [31:0] rd, output logic e);
        int sz, base;
        bit undef;
        longint val;
        sz    = (f3 == 0 || (!mw && f3 == 4)) ? 1 : (f3 == 1 || (!mw && f3 == 5)) ? 2 : 4;
        undef = mw ? (f3 > 2) : (f3 == 3 || f3 >= 6);
        e     = ERR_EN && (undef || (a % sz) != 0);
        rd    = '0;
        if (e) return;
        base = int'(a % 4096);
        base -= base % sz;
        if (mw) begin
            for (int i = 0; i < sz; i++) ref_b[base + i] = wd[8*i +: 8];
        end else begin
            val = 0;
            for (int i = 0; i < sz; i++) val += longint'(ref_b[base + i]) << (8 * i);
            if ((f3 == 0 || f3 == 1) && val >= (64'sd1 << (8 * sz - 1))) val -= 64'sd1 << (8 * sz);
            rd = 32'(val);
        end
    endfunction

    // Called at a negedge; returns at the negedge after the response cycle.
    task automatic access(input logic mw, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rd, output logic e,
                          output int lat);
        int t = 0;
        while (!req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) begin
            check("req_ready timeout", 32'd0, 32'd1);
            rd  = 'x;
            e   = 'x;
            lat = -1;
            return;
        end
        mem_w = mw; funct3 = f3; addr = a; wdata = wd; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 50);
        rd = rdata;
        e  = err;
        @(negedge clk);
        check("rsp_valid one-cycle", {31'd0, rsp_valid}, 32'd0);
        check("rdata hold", rdata, rd);
    endtask

    typedef struct {
        logic        mw;
        logic [2:0]  f3;
        logic [31:0] a, wd, rd;
        logic        e;
    } vec_t;

    vec_t v[$];

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, exp_rd;
        logic        e, exp_e;
        int          lat;
        bit          seen;

        v.push_back('{1, 3'b010, 32'h10,   32'hDEADBEEF, 32'h0,        0});
        v.push_back('{0, 3'b010, 32'h10,   32'h0,        32'hDEADBEEF, 0});
        v.push_back('{1, 3'b010, 32'h10,   32'h0,        32'h0,        0});
        v.push_back('{1, 3'b000, 32'h13,   32'h80,       32'h0,        0});
        v.push_back('{0, 3'b000, 32'h13,   32'h0,        32'hFFFFFF80, 0});
        v.push_back('{0, 3'b100, 32'h13,   32'h0,        32'h00000080, 0});
        v.push_back('{0, 3'b010, 32'h10,   32'h0,        32'h80000000, 0});
        v.push_back('{1, 3'b010, 32'h20,   32'hAAAAAAAA, 32'h0,        0});
        v.push_back('{1, 3'b001, 32'h22,   32'h1234,     32'h0,        0});
        v.push_back('{0, 3'b010, 32'h20,   32'h0,        32'h1234AAAA, 0});
        v.push_back('{0, 3'b010, 32'h21,   32'h0,        ERR_EN ? 32'h0 : 32'h1234AAAA, ERR_EN});
        v.push_back('{0, 3'b010, 32'h20,   32'h0,        32'h1234AAAA, 0});
        v.push_back('{0, 3'b001, 32'h22,   32'h0,        32'h00001234, 0});
        v.push_back('{1, 3'b001, 32'h20,   32'h8001,     32'h0,        0});
        v.push_back('{0, 3'b001, 32'h20,   32'h0,        32'hFFFF8001, 0});
        v.push_back('{0, 3'b101, 32'h20,   32'h0,        32'h00008001, 0});
        v.push_back('{0, 3'b011, 32'h20,   32'h0,        ERR_EN ? 32'h0 : 32'h12348001, ERR_EN});
        v.push_back('{1, 3'b000, 32'h21,   32'hFFFFFF55, 32'h0,        0});
        v.push_back('{0, 3'b010, 32'h20,   32'h0,        32'h12345501, 0});
        v.push_back('{1, 3'b001, 32'h23,   32'h0000BEEF, 32'h0,        ERR_EN});
        v.push_back('{0, 3'b010, 32'h20,   32'h0,        ERR_EN ? 32'h12345501 : 32'hBEEF5501, 0});
        v.push_back('{1, 3'b010, 32'h1000, 32'h5,        32'h0,        0});
        v.push_back('{0, 3'b010, 32'h0,    32'h0,        32'h5,        0});
        v.push_back('{0, 3'b010, 32'h1000, 32'h0,        32'h5,        0});
        v.push_back('{1, 3'b010, 32'h24,   32'h0,        32'h0,        0});
        v.push_back('{1, 3'b111, 32'h24,   32'hCAFEF00D, 32'h0,        ERR_EN});
        v.push_back('{0, 3'b010, 32'h24,   32'h0,        ERR_EN ? 32'h0 : 32'hCAFEF00D, 0});

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset req_ready", {31'd0, req_ready}, 32'd1);
        check("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset err", {31'd0, err}, 32'd0);
        check("reset rdata", rdata, 32'd0);

        foreach (v[k]) begin
            access(v[k].mw, v[k].f3, v[k].a, v[k].wd, rd, e, lat);
            check($sformatf("vec%0d rdata", k), rd, v[k].rd);
            check($sformatf("vec%0d err", k), {31'd0, e}, {31'd0, v[k].e});
            check($sformatf("vec%0d latency", k), lat, v[k].e ? 1 : WC + 2);
        end

        // Reset during WAIT of a store: store dropped, no response.
        access(1, 3'b010, 32'h30, 32'h11111111, rd, e, lat);
        access(0, 3'b010, 32'h30, 32'h0, rd, e, lat);
        check("pre-abort load", rd, 32'h11111111);
        mem_w = 1; funct3 = 3'b010; addr = 32'h30; wdata = 32'h77; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        reset = 1'b1;
        seen = 1'b0;
        @(negedge clk);
        seen |= rsp_valid;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("abort req_ready", {31'd0, req_ready}, 32'd1);
        check("abort rdata cleared", rdata, 32'd0);
        repeat (4) begin
            seen |= rsp_valid;
            @(negedge clk);
        end
        check("abort no rsp_valid", {31'd0, seen}, 32'd0);
        access(0, 3'b010, 32'h30, 32'h0, rd, e, lat);
        check("abort word kept", rd, 32'h11111111);

        // Reset while in ACCESS: store has committed, response suppressed.
        mem_w = 1; funct3 = 3'b010; addr = 32'h34; wdata = 32'h99; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        seen = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen |= rsp_valid;
        end
        check("access-reset no rsp_valid", {31'd0, seen}, 32'd0);
        access(0, 3'b010, 32'h34, 32'h0, rd, e, lat);
        check("access-reset store committed", rd, 32'h99);

        // Random phase confined to words 0..63 with random upper address bits.
        for (int i = 0; i < 64; i++) begin
            logic [31:0] d;
            d = $urandom;
            model(1, 3'b010, 32'(i * 4), d, exp_rd, exp_e);
            access(1, 3'b010, 32'(i * 4), d, rd, e, lat);
        end
        for (int i = 0; i < 300; i++) begin
            logic        mw;
            logic [2:0]  f3;
            logic [31:0] a, d;
            mw = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom & 32'hFFFF_F0FF;
            d  = $urandom;
            model(mw, f3, a, d, exp_rd, exp_e);
            access(mw, f3, a, d, rd, e, lat);
            check($sformatf("rand%0d rdata mw=%0d f3=%0d a=%h", i, mw, f3, a), rd, exp_rd);
            check($sformatf("rand%0d err", i), {31'd0, e}, {31'd0, exp_e});
            check($sformatf("rand%0d latency", i), lat, exp_e ? 1 : WC + 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: data RAM size in 32-bit words, power of two.
REQ-002 Parameter WAIT_CYCLES, default 1: extra wait cycles before each access, range 0..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  access request from CPU memory stage.
REQ-006 req_ready  output  1  block can accept a request this cycle.
REQ-007 mem_w  input  1  1 = store, 0 = load.
REQ-008 funct3  input  3  RISC-V width/sign code (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-009 addr  input  32  byte address (CPU ALU result).
REQ-010 wdata  input  32  store data (CPU rs2 value).
REQ-011 rdata  output  32  load result, extended to 32 bits.
REQ-012 rsp_valid  output  1  one-cycle pulse: access complete, rdata/err valid.
REQ-013 err  output  1  access rejected; qualified by rsp_valid.

Function
REQ-014 FSM states: IDLE, WAIT, ACCESS, RESP.
REQ-015 req_ready SHALL be 1 only in IDLE; handshake = req_valid & req_ready.
REQ-016 On handshake, SHALL capture mem_w, funct3, addr, wdata; go to WAIT if WAIT_CYCLES>0, else ACCESS.
REQ-017 WAIT SHALL count WAIT_CYCLES cycles, then go to ACCESS.
REQ-018 ACCESS: store commits byte-enabled write; load reads word. Next state RESP.
REQ-019 RESP: rsp_valid=1 for exactly one cycle; next state IDLE. Requests presented in RESP are not accepted.
REQ-020 Latency SHALL be WAIT_CYCLES+2 cycles from handshake to rsp_valid; throughput one access per WAIT_CYCLES+3 cycles.
REQ-021 Word index = addr[log2(DEPTH_WORDS)+1:2]; higher address bits ignored (wrap modulo RAM size).
REQ-022 SB writes lane addr[1:0] with wdata[7:0]; SH writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0]; SW writes all four lanes.
REQ-023 LB/LH sign-extend; LBU/LHU zero-extend; LW returns word unchanged.
REQ-024 rdata for stores SHALL be 0; rdata SHALL hold its value outside RESP.
REQ-025 Load and store to the same word in consecutive requests: load returns the newly stored data.

Reset
REQ-026 Reset SHALL force IDLE, clear counter and captured request, rsp_valid=0, err=0, rdata=0; req_ready=1 in the cycle after reset deasserts.
REQ-027 Reset in WAIT SHALL abort and discard the pending store; reset in RESP suppresses rsp_valid. A store already committed in ACCESS remains committed.
REQ-028 RAM contents SHALL NOT be cleared by reset.

Configuration
REQ-029 Macro DMEM_ERR_EN. When defined: misaligned access (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0) or undefined funct3 (load 011/110/111, store >010) SHALL skip WAIT/ACCESS, leave RAM unchanged, go directly to RESP with err=1, rdata=0, latency 1 cycle.
REQ-030 When DMEM_ERR_EN is not defined: err SHALL be tied 0; the low address bits below access size are ignored (force-aligned); undefined funct3 is treated as LW/SW.

Structure
REQ-031 Shared package dmem_pkg SHALL hold funct3 encodings (LB..LHU, SB..SW) and the FSM state encoding.
REQ-032 Sub-module dmem_ram: single-port DEPTH_WORDS x 32 RAM with 4-bit byte write enable and registered read.

Verification
REQ-033 WAIT_CYCLES=1: SW addr=0x10, wdata=0xDEADBEEF, then LW 0x10 -> rsp_valid 3 cycles after each handshake, rdata=0xDEADBEEF.
REQ-034 SB 0x13 wdata=0x80 over word 0x00000000, LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080.
REQ-035 SH 0x22 wdata=0x1234 over word 0xAAAAAAAA, LW 0x20 -> 0x1234AAAA.
REQ-036 DMEM_ERR_EN defined: LW addr=0x21 -> rsp_valid next cycle, err=1, rdata=0, word 0x20 unchanged; undefined: same request returns word 0x20, err=0.
REQ-037 DEPTH_WORDS=1024: SW addr=0x1000 wdata=0x5 -> LW 0x0 returns 0x5 (wrap).
REQ-038 Assert reset in WAIT of SW 0x30 wdata=0x77 -> no rsp_valid, word 0x30 retains prior value, req_ready=1 after reset deasserts.
